gshare_bpu: RTL and testbench
=============================

# gshare_bpu

Parametrised dual-lane branch predictor; next generation of the core's 2-bit bimodal BHT. Adds configurable table depth and counter width, an optional gshare index (PC XOR global history), speculative global-history tracking with mispredict recovery, and defined same-entry update merging. After reset, a sequential init sweep clears the table. Sits beside fetch (lookup) and execute (update/recovery) in the dual-issue pipeline.

## Interface
- PC_W, 8: PC width.
- IDX_W, 8: table index width; 2^IDX_W entries; IDX_W <= PC_W.
- CTR_W, 2: saturating counter width, >= 2.
- HIST_W, 4: global history width, 2..IDX_W.
- GSHARE, 1: 1 = index is pc[IDX_W-1:0] ^ zero-extended history; 0 = pc[IDX_W-1:0] only (bimodal).
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- fetch_stall  in  1  holds speculative history.
- pc1_f, pc2_f  in  PC_W  fetch PCs, lane 1 (older) and lane 2.
- branch1_f, branch2_f  in  1  lane holds a conditional branch (predecode).
- pred1_f, pred2_f  out  1  predicted taken.
- hist1_f, hist2_f  out  HIST_W  history used for each lane's index; carried down the pipe.
- pc1_e, pc2_e  in  PC_W  execute PCs.
- hist1_e, hist2_e  in  HIST_W  history carried from fetch.
- branch1_e, branch2_e  in  1  resolved branch in lane.
- taken1_e, taken2_e  in  1  actual outcome.
- mispred1_e, mispred2_e  in  1  lane mispredicted.
- ready  out  1  table initialised; lookups/updates valid.

## Operation
- Table: 2^IDX_W counters, CTR_W bits. Init value 2^(CTR_W-1)-1 (weakly not-taken). Prediction = counter MSB.
- Counter update: taken -> +1 saturating at 2^CTR_W-1; not taken -> -1 saturating at 0.
- Speculative history G (HIST_W bits). Shift: G' = {G[HIST_W-2:0], bit}.
- Lookup (combinational): hist1_f = G; idx1 = f(pc1_f, hist1_f). hist2_f = shift(G, pred1_f) if branch1_f else G; idx2 = f(pc2_f, hist2_f).
- Lane-2 squash: if branch1_f & pred1_f, lane 2 is treated as non-branch for history.
- Fetch history update (ready & ~fetch_stall, no recovery): G advances by lane-1 shift if branch1_f, then lane-2 shift if branch2_f and not squashed (0, 1 or 2 shifts).
- Execute update (ready): lane x updates entry f(pc_x_e, hist_x_e) when branch_x_e.
- If mispred1_e & branch1_e: lane-2 update suppressed (wrong path); G <= shift(hist1_e, taken1_e).
- Else if mispred2_e & branch2_e: G <= shift(hist2_e, taken2_e).
- Recovery overrides the fetch history update in the same cycle, including under fetch_stall.
- Same-entry collision (both lanes update the same index): sequential merge, ctr' = upd(upd(ctr, taken1_e), taken2_e).
- Init FSM: INIT -> RUN. INIT writes one entry per cycle, index 0 upward. Enters RUN after entry 2^IDX_W-1. In INIT: ready=0, preds 0, updates ignored, G held 0.
- reset in any state -> INIT, sweep pointer 0, G=0.

## Timing
- Reset values: ready=0, pred1_f=pred2_f=0, hist1_f=hist2_f=0, G=0, sweep pointer 0.
- Init: 2^IDX_W cycles after the first cycle with reset low; ready rises on the following edge and stays high until reset.
- Prediction: zero-cycle combinational from current table and G.
- Table write and G change: visible one cycle later.
- No write-to-read bypass: a lookup in the same cycle as an update to that entry sees the pre-update value.

## Test plan
- Reset 1 cycle, defaults -> ready=0 for 256 cycles, then 1; every pc with G=0 predicts 0 (counter 01).
- Lane-1 updates at pc 0x10, hist 0: taken x3 -> counter 01,10,11,11 (pred 1 after the first); then not-taken x3 -> 10,01,00.
- Both lanes update pc 0x20, hist 0, taken, same cycle -> entry 01->11; pred 1 next cycle. Lane 1 taken + lane 2 not-taken on the same entry -> stays 01.
- G=0000; branch1_f with pred1_f=0 and branch2_f=1 -> hist2_f=0000, G=0000 then 0000 (two 0 shifts). With pred1_f=1 -> lane 2 squashed, G becomes 0001; lane-2 index = pc2_f ^ 0x01.
- mispred1_e and mispred2_e both set, hist1_e=0101, taken1_e=0, with fetch shifting in the same cycle -> G=1010; lane-2 table entry unchanged.
- reset asserted at cycle 100 of the sweep -> ready stays 0 for a further full 256 cycles; updates in between have no effect.

Source files
------------

// File: rtl/gshare_bpu.sv
// Dual-lane gshare/bimodal branch predictor with speculative global history,
// mispredict recovery, same-entry update merging and a post-reset table sweep.
module gshare_bpu #(
  parameter int PC_W   = 8,
  parameter int IDX_W  = 8,
  parameter int CTR_W  = 2,
  parameter int HIST_W = 4,
  parameter int GSHARE = 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_fetch_stall,
  input  logic [PC_W-1:0]   i_pc1_f,
  input  logic [PC_W-1:0]   i_pc2_f,
  input  logic              i_branch1_f,
  input  logic              i_branch2_f,
  output logic              o_pred1_f,
  output logic              o_pred2_f,
  output logic [HIST_W-1:0] o_hist1_f,
  output logic [HIST_W-1:0] o_hist2_f,
  input  logic [PC_W-1:0]   i_pc1_e,
  input  logic [PC_W-1:0]   i_pc2_e,
  input  logic [HIST_W-1:0] i_hist1_e,
  input  logic [HIST_W-1:0] i_hist2_e,
  input  logic              i_branch1_e,
  input  logic              i_branch2_e,
  input  logic              i_taken1_e,
  input  logic              i_taken2_e,
  input  logic              i_mispred1_e,
  input  logic              i_mispred2_e,
  output logic              o_ready,
  output logic              o_dbg_state
);

  localparam int              DEPTH    = 1 << IDX_W;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;
  localparam logic [CTR_W-1:0] CTR_ZERO = '0;
  localparam logic [CTR_W-1:0] CTR_ONE  = CTR_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = '1;

  typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

  state_t            r_state, w_state_nxt;
  logic [IDX_W-1:0]  r_ptr, w_ptr_nxt;
  logic [HIST_W-1:0] r_g, w_g_nxt;
  logic [CTR_W-1:0]  r_table [DEPTH];

  function automatic logic [IDX_W-1:0] f_idx(input logic [PC_W-1:0] pc,
                                             input logic [HIST_W-1:0] h);
    logic [IDX_W-1:0] hx;
    hx = '0;
    hx[HIST_W-1:0] = h;
    f_idx = (GSHARE != 0) ? (pc[IDX_W-1:0] ^ hx) : pc[IDX_W-1:0];
  endfunction

  function automatic logic [HIST_W-1:0] f_shift(input logic [HIST_W-1:0] h,
                                                input logic b);
    f_shift = {h[HIST_W-2:0], b};
  endfunction

  function automatic logic [CTR_W-1:0] f_upd(input logic [CTR_W-1:0] c,
                                             input logic t);
    if (t) f_upd = (c == CTR_MAX) ? c : c + CTR_ONE;
    else   f_upd = (c == CTR_ZERO) ? c : c - CTR_ONE;
  endfunction

  logic              w_ready;
  logic [IDX_W-1:0]  w_idx1, w_idx2, w_eidx1, w_eidx2;
  logic [HIST_W-1:0] w_hist2, w_g_fetch;
  logic              w_pred1, w_pred2, w_squash;
  logic              w_wrong_path, w_rec1, w_rec2;
  logic              w_upd1, w_upd2, w_same;
  logic [CTR_W-1:0]  w_new1, w_new2, w_merged;

  // Fetch-side lookup: lane 2 indexes with history already shifted by lane 1.
  assign w_ready   = (r_state == S_RUN);
  assign w_idx1    = f_idx(i_pc1_f, r_g);
  assign w_pred1   = w_ready & r_table[w_idx1][CTR_W-1];
  assign w_hist2   = i_branch1_f ? f_shift(r_g, w_pred1) : r_g;
  assign w_idx2    = f_idx(i_pc2_f, w_hist2);
  assign w_pred2   = w_ready & r_table[w_idx2][CTR_W-1];
  assign w_squash  = i_branch1_f & w_pred1;
  assign w_g_fetch = (i_branch2_f & ~w_squash) ? f_shift(w_hist2, w_pred2) : w_hist2;

  assign o_pred1_f   = w_pred1;
  assign o_pred2_f   = w_pred2;
  assign o_hist1_f   = r_g;
  assign o_hist2_f   = w_hist2;
  assign o_ready     = w_ready;
  assign o_dbg_state = r_state;

  // A lane-1 mispredict means lane 2 was on the wrong path: no update from it.
  assign w_wrong_path = i_mispred1_e & i_branch1_e;
  assign w_rec1       = w_ready & w_wrong_path;
  assign w_rec2       = w_ready & ~w_wrong_path & i_mispred2_e & i_branch2_e;
  assign w_upd1       = w_ready & i_branch1_e;
  assign w_upd2       = w_ready & i_branch2_e & ~w_wrong_path;
  assign w_eidx1      = f_idx(i_pc1_e, i_hist1_e);
  assign w_eidx2      = f_idx(i_pc2_e, i_hist2_e);
  assign w_same       = w_upd1 & w_upd2 & (w_eidx1 == w_eidx2);
  assign w_new1       = f_upd(r_table[w_eidx1], i_taken1_e);
  assign w_new2       = f_upd(r_table[w_eidx2], i_taken2_e);
  assign w_merged     = f_upd(w_new1, i_taken2_e);

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_g_nxt     = r_g;
    case (r_state)
      S_INIT: begin
        w_ptr_nxt = r_ptr + IDX_W'(1);
        w_g_nxt   = '0;
        if (r_ptr == IDX_LAST) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (w_rec1)              w_g_nxt = f_shift(i_hist1_e, i_taken1_e);
        else if (w_rec2)         w_g_nxt = f_shift(i_hist2_e, i_taken2_e);
        else if (!i_fetch_stall) w_g_nxt = w_g_fetch;
      end
      default: w_state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_INIT;
      r_ptr   <= '0;
      r_g     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_g     <= w_g_nxt;
    end
  end

  // Table has no reset; the INIT sweep rewrites every entry before use.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      if (r_state == S_INIT) begin
        r_table[r_ptr] <= CTR_INIT;
      end else if (w_same) begin
        r_table[w_eidx1] <= w_merged;
      end else begin
        if (w_upd1) r_table[w_eidx1] <= w_new1;
        if (w_upd2) r_table[w_eidx2] <= w_new2;
      end
    end
  end

endmodule

// File: tb/tb_gshare_bpu.sv
// Bench for gshare_bpu: directed and random stimulus against a behavioural
// predictor model; expected fetch outputs are queued and checked by a monitor.
module tb_gshare_bpu;

  logic       clk = 1'b0;
  logic       reset;
  logic       fetch_stall;
  logic [7:0] pc1_f, pc2_f;
  logic       branch1_f, branch2_f;
  logic       pred1_f, pred2_f;
  logic [3:0] hist1_f, hist2_f;
  logic [7:0] pc1_e, pc2_e;
  logic [3:0] hist1_e, hist2_e;
  logic       branch1_e, branch2_e, taken1_e, taken2_e, mispred1_e, mispred2_e;
  logic       ready;
  logic       dbg_state;

  always #5 clk = ~clk;

  gshare_bpu #(.PC_W(8), .IDX_W(8), .CTR_W(2), .HIST_W(4), .GSHARE(1)) dut (
    .i_clk(clk), .i_reset(reset), .i_fetch_stall(fetch_stall),
    .i_pc1_f(pc1_f), .i_pc2_f(pc2_f),
    .i_branch1_f(branch1_f), .i_branch2_f(branch2_f),
    .o_pred1_f(pred1_f), .o_pred2_f(pred2_f),
    .o_hist1_f(hist1_f), .o_hist2_f(hist2_f),
    .i_pc1_e(pc1_e), .i_pc2_e(pc2_e),
    .i_hist1_e(hist1_e), .i_hist2_e(hist2_e),
    .i_branch1_e(branch1_e), .i_branch2_e(branch2_e),
    .i_taken1_e(taken1_e), .i_taken2_e(taken2_e),
    .i_mispred1_e(mispred1_e), .i_mispred2_e(mispred2_e),
    .o_ready(ready), .o_dbg_state(dbg_state)
  );

  // Expected vector: {ready, pred1, pred2, hist1[3:0], hist2[3:0]}
  logic [10:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: counters as plain integers 0..3, history as 0..15.
  int m_ctr [256];
  int m_g;
  bit m_ready;
  int m_cnt;

  function automatic int m_idx(input int pc, input int h);
    return (pc ^ h) & 255;
  endfunction

  function automatic int m_sat(input int v);
    if (v < 0) return 0;
    if (v > 3) return 3;
    return v;
  endfunction

  task automatic set_fetch(input int p1, input int p2, input bit b1,
                           input bit b2, input bit st);
    pc1_f = 8'(p1); pc2_f = 8'(p2); branch1_f = b1; branch2_f = b2;
    fetch_stall = st;
  endtask

  task automatic set_exec(input bit b1, input int p1, input int h1, input bit t1,
                          input bit m1, input bit b2, input int p2, input int h2,
                          input bit t2, input bit m2);
    branch1_e = b1; pc1_e = 8'(p1); hist1_e = 4'(h1); taken1_e = t1; mispred1_e = m1;
    branch2_e = b2; pc2_e = 8'(p2); hist2_e = 4'(h2); taken2_e = t2; mispred2_e = m2;
  endtask

  task automatic set_idle();
    set_fetch(0, 0, 0, 0, 0);
    set_exec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rand_inputs(input bit allow_mispred);
    set_fetch($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 1),
              $urandom_range(0, 1), ($urandom_range(0, 7) == 0));
    set_exec($urandom_range(0, 1), $urandom_range(0, 255), $urandom_range(0, 15),
             ($urandom_range(0, 3) != 0), allow_mispred && ($urandom_range(0, 7) == 0),
             $urandom_range(0, 1), $urandom_range(0, 255), $urandom_range(0, 15),
             ($urandom_range(0, 3) != 0), allow_mispred && ($urandom_range(0, 7) == 0));
    // Occasionally aim both execute lanes at the same entry.
    if ($urandom_range(0, 3) == 0) begin
      pc2_e = pc1_e; hist2_e = hist1_e;
    end
  endtask

  // One cycle: queue the expected outputs for the inputs now applied, then
  // advance the model across the clock edge.
  task automatic step();
    bit p1, p2;
    int h2, i;
    p1 = m_ready && (m_ctr[m_idx(pc1_f, m_g)] >= 2);
    h2 = branch1_f ? (((m_g << 1) | int'(p1)) & 15) : m_g;
    p2 = m_ready && (m_ctr[m_idx(pc2_f, h2)] >= 2);
    exp_q.push_back({m_ready, p1, p2, 4'(m_g), 4'(h2)});
    @(posedge clk);
    if (reset) begin
      m_ready = 0; m_cnt = 0; m_g = 0;
    end else if (!m_ready) begin
      m_cnt++;
      if (m_cnt == 256) begin
        m_ready = 1;
        for (int k = 0; k < 256; k++) m_ctr[k] = 1;
      end
    end else begin
      if (branch1_e) begin
        i = m_idx(pc1_e, hist1_e);
        m_ctr[i] = m_sat(m_ctr[i] + (taken1_e ? 1 : -1));
      end
      if (branch2_e && !(mispred1_e && branch1_e)) begin
        i = m_idx(pc2_e, hist2_e);
        m_ctr[i] = m_sat(m_ctr[i] + (taken2_e ? 1 : -1));
      end
      if (mispred1_e && branch1_e)      m_g = ((hist1_e << 1) | taken1_e) & 15;
      else if (mispred2_e && branch2_e) m_g = ((hist2_e << 1) | taken2_e) & 15;
      else if (!fetch_stall) begin
        m_g = h2;
        if (branch2_f && !(branch1_f && p1)) m_g = ((m_g << 1) | int'(p2)) & 15;
      end
    end
    #1;
  endtask

  // Monitor: the bench's outputs are combinational every cycle, so each
  // negedge presents one result to compare against the queue head.
  initial begin
    logic [10:0] e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {ready, pred1_f, pred2_f, hist1_f, hist2_f};
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL outputs t=%0t actual{rdy,p1,p2,h1,h2}=%b_%b_%b_%h_%h required=%b_%b_%b_%h_%h",
                   $time, a[10], a[9], a[8], a[7:4], a[3:0], e[10], e[9], e[8], e[7:4], e[3:0]);
        end
      end
    end
  end

  initial begin
    m_g = 0; m_ready = 0; m_cnt = 0;
    for (int k = 0; k < 256; k++) m_ctr[k] = 1;
    reset = 1'b1;
    set_idle();
    @(posedge clk); #1;

    // Reset then full sweep; lookups across many pcs must stay 0.
    step();
    reset = 1'b0;
    for (int c = 0; c < 262; c++) begin
      pc1_f = 8'(c); pc2_f = 8'(c + 7);
      step();
    end
    set_idle();

    // Lane-1 training at pc 0x10, hist 0: 3 taken then 3 not-taken.
    pc1_f = 8'h10;
    for (int c = 0; c < 6; c++) begin
      set_exec(1, 'h10, 0, (c < 3), 0, 0, 0, 0, 0, 0);
      step();
    end
    set_exec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();

    // Both lanes on 0x20: taken+taken, then taken+not-taken elsewhere.
    pc1_f = 8'h20; pc2_f = 8'h30;
    set_exec(1, 'h20, 0, 1, 0, 1, 'h20, 0, 1, 0); step();
    set_exec(1, 'h30, 0, 1, 0, 1, 'h30, 0, 0, 0); step();
    set_exec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);       step();
    step();

    // History: not-predicted lane 1 plus lane 2, then predicted-taken lane 1.
    set_fetch('h40, 'h41, 1, 1, 0); step();
    set_fetch('h20, 'h21, 1, 1, 0); step();
    set_fetch('h20, 'h21, 0, 0, 0); step();

    // Double mispredict with fetch shifting: recovery wins, lane 2 dropped.
    set_fetch('h20, 'h21, 1, 1, 0);
    set_exec(1, 'h50, 'h5, 0, 1, 1, 'h60, 'h3, 1, 1); step();
    set_idle();
    pc1_f = 8'h5A; pc2_f = 8'h63; step();
    set_fetch('h20, 'h21, 1, 1, 1);
    set_exec(0, 0, 0, 0, 0, 1, 'h60, 'h9, 1, 1); step();
    set_idle(); step();

    // Random traffic.
    for (int c = 0; c < 1500; c++) begin
      rand_inputs(1);
      step();
    end

    // Reset mid-sweep, with updates arriving during initialisation.
    set_idle(); reset = 1'b1; step();
    reset = 1'b0;
    for (int c = 0; c < 100; c++) begin rand_inputs(1); step(); end
    reset = 1'b1; step();
    reset = 1'b0;
    for (int c = 0; c < 260; c++) begin rand_inputs(1); step(); end
    for (int c = 0; c < 400; c++) begin rand_inputs(($urandom_range(0, 1) == 1)); step(); end

    set_idle();
    @(negedge clk); #1;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain actual_pending=%0d required=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
